dez_akkumulator: RTL and testbench

Parametrised decimal accumulator for the punched-card counting section, successor to the fixed 12-place ES24 counter. Adds or subtracts one card field per card cycle into `DIGITS` BCD places, driven by index-point strobes from the timing chain and hole data from the second brush. A sequenced carry phase follows, plus zero and all-nines analysis, sticky overflow and deferred clear. Sits between the brush/timing front end and the print/analysis logic.

---
 rtl/dez_pkg.sv | 28 ++
 rtl/dez_stelle.sv | 58 +++++
 rtl/dez_akkumulator.sv | 149 ++++++++++++++
 tb/tb_dez_akkumulator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dez_pkg.sv
// dez_pkg: shared types and constants for the decimal accumulator.
// FSM states, card operation codes, timing-chain index points and a
// BCD successor helper used by every accumulator place.
package dez_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CARRY
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB
  } op_t;

  // Index points delivered by the timing chain with each strobe.
  localparam logic [3:0] T_INIT  = 4'd12;
  localparam logic [3:0] T_FIRST = 4'd9;
  localparam logic [3:0] T_LAST  = 4'd0;

  // Mod-10 successor of one BCD place.
  function automatic logic [3:0] bcd_succ(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/dez_stelle.sv
// dez_stelle: one decimal place of the accumulator.
// Holds the BCD counter, the hole latch of the current card column and
// the pending-carry flag that the next place consumes in the carry phase.
module dez_stelle
  import dez_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,      // zero the place
  input  logic       init,       // card start: forget hole and carry
  input  logic       read_stb,   // index-point strobe 9..0 during READ
  input  logic       sub,        // current card subtracts
  input  logic       last,       // this strobe is index point 0
  input  logic       hole,       // brush hole for this column
  input  logic       carry_in,   // carry from the place below
  input  logic       carry_ack,  // the place above took our carry
  output logic [3:0] bcd,
  output logic       carry_pend
);

  logic hole_seen;
  logic count;
  logic wrap;

  // Decide whether this place counts one step in the current cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    count = carry_in;
    if (read_stb) begin
      // Subtraction never counts on index point 0, so a blank column
      // yields 9 exactly like a hole in the 0 row.
      if (sub) count = !hole_seen && !hole && !last;
      else     count = hole_seen;
    end
    wrap = count && (bcd == 4'd9);
  end

  // Place register, hole latch and pending carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      bcd        <= 4'd0;
      hole_seen  <= 1'b0;
      carry_pend <= 1'b0;
    end else begin
      if (clear)      bcd <= 4'd0;
      else if (count) bcd <= bcd_succ(bcd);

      if (init)                  hole_seen <= 1'b0;
      else if (read_stb && hole) hole_seen <= 1'b1;

      // A consumed carry and a fresh wrap may coincide; the wrap wins.
      if (init) carry_pend <= 1'b0;
      else      carry_pend <= (carry_pend && !carry_ack) || wrap;
    end
  end

endmodule

// File: rtl/dez_akkumulator.sv
// dez_akkumulator: parametrised BCD card accumulator.
// Adds or subtracts one card per card cycle, then runs a sequenced carry
// phase. Define DEZ_END_AROUND_CARRY_EN to feed the top-place carry of a
// subtract card back into place 0 (nines-complement end-around carry);
// otherwise every top-place carry is discarded and sets overflow.
module dez_akkumulator
  import dez_pkg::*;
#(
  parameter int DIGITS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  time_strobe,
  input  logic [3:0]            time_idx,
  input  logic [DIGITS-1:0]     data,
  input  logic                  add_req,
  input  logic                  sub_req,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  busy,
  output logic                  done,
  output logic                  is_zero,
  output logic                  is_nines,
  output logic                  overflow
);

  state_t            state;
  op_t               op;
  logic              clr_pend;

  logic              start;
  logic              do_clear;
  logic              read_stb;
  logic              last_stb;
  logic              in_carry;
  logic              op_sub;
  logic              top_carry;
  logic              wrap_around;
  logic              ovf_set;
  logic              all_zero;
  logic              all_nines;
  logic [DIGITS-1:0] pend;
  logic [DIGITS-1:0] carry_in;
  logic [DIGITS-1:0] carry_ack;
  logic [3:0]        place_bcd [DIGITS];

  // Sequencing controls shared by all places.
  always_comb begin
    start     = (state == S_IDLE) && time_strobe && (time_idx == T_INIT)
                && (add_req ^ sub_req);
    // A held clear lands in IDLE before any new card is started.
    do_clear  = (state == S_IDLE) && (clr || clr_pend);
    read_stb  = (state == S_READ) && time_strobe && (time_idx <= T_FIRST);
    last_stb  = read_stb && (time_idx == T_LAST);
    in_carry  = (state == S_CARRY);
    op_sub    = (op == OP_SUB);
    top_carry = in_carry && pend[DIGITS-1];
`ifdef DEZ_END_AROUND_CARRY_EN
    wrap_around = top_carry && op_sub;
    ovf_set     = top_carry && !op_sub;
`else
    wrap_around = 1'b0;
    ovf_set     = top_carry;
`endif
    // Every pending carry is taken in the carry phase; the top one goes
    // either around to place 0 or out as overflow.
    carry_in  = in_carry ? {pend[DIGITS-2:0], wrap_around} : '0;
    carry_ack = in_carry ? pend : '0;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_stelle
    dez_stelle u_stelle (
      .clk        (clk),
      .reset      (reset),
      .clear      (do_clear),
      .init       (start),
      .read_stb   (read_stb),
      .sub        (op_sub),
      .last       (last_stb),
      .hole       (data[i]),
      .carry_in   (carry_in[i]),
      .carry_ack  (carry_ack[i]),
      .bcd        (place_bcd[i]),
      .carry_pend (pend[i])
    );
  end

  // Pack the places and evaluate the zero / all-nines analysis.
  always_comb begin
    digits    = '0;
    all_zero  = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digits[4*i +: 4] = place_bcd[i];
      if (place_bcd[i] != 4'd0) all_zero  = 1'b0;
      if (place_bcd[i] != 4'd9) all_nines = 1'b0;
    end
  end

  // Card-cycle FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op       <= OP_NONE;
      clr_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      is_zero  <= 1'b1;
      is_nines <= 1'b0;
    end else begin
      done     <= 1'b0;
      is_zero  <= all_zero;
      is_nines <= all_nines;

      if (state != S_IDLE && clr) clr_pend <= 1'b1;
      else if (do_clear)          clr_pend <= 1'b0;

      if (do_clear)     overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            busy  <= 1'b1;
            op    <= add_req ? OP_ADD : OP_SUB;
          end
        end
        S_READ: begin
          if (last_stb) state <= S_CARRY;
        end
        S_CARRY: begin
          if (pend == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            op    <= OP_NONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dez_akkumulator.sv
// tb_dez_akkumulator: scoreboard bench for dez_akkumulator with DIGITS=4.
// The stimulus side computes each card's effect with plain integer
// arithmetic and queues the expected result; a monitor compares on done.
module tb_dez_akkumulator;

  localparam int     D   = 4;
  localparam longint MOD = 10000;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           time_strobe = 1'b0;
  logic [3:0]     time_idx = 4'd0;
  logic [D-1:0]   data = '0;
  logic           add_req = 1'b0;
  logic           sub_req = 1'b0;
  logic           clr = 1'b0;
  logic [4*D-1:0] digits;
  logic           busy;
  logic           done;
  logic           is_zero;
  logic           is_nines;
  logic           overflow;

  dez_akkumulator #(.DIGITS(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .time_strobe (time_strobe),
    .time_idx    (time_idx),
    .data        (data),
    .add_req     (add_req),
    .sub_req     (sub_req),
    .clr         (clr),
    .digits      (digits),
    .busy        (busy),
    .done        (done),
    .is_zero     (is_zero),
    .is_nines    (is_nines),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint value;
    bit     ovf;
    bit     clr_after;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint acc = 0;
  bit     acc_ovf = 1'b0;
  int     hole_d[D];   // first hole row per column, -1 = blank
  int     hole_x[D];   // later extra hole row, -1 = none
  bit     clr_chk = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input longint v);
    logic [4*D-1:0] r;
    longint t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint card_value();
    longint v;
    longint w;
    v = 0;
    w = 1;
    for (int i = 0; i < D; i++) begin
      if (hole_d[i] >= 0) v += hole_d[i] * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [D-1:0] holes_at(input int k);
    logic [D-1:0] b;
    for (int i = 0; i < D; i++) b[i] = (hole_d[i] == k) || (hole_x[i] == k);
    return b;
  endfunction

  // Reference: a card adds its value, a subtract card adds the nines complement.
  task automatic model_card(input bit sub, input bit clr_after);
    longint s;
    exp_t   e;
    if (!sub) begin
      s = acc + card_value();
      if (s >= MOD) begin s -= MOD; acc_ovf = 1'b1; end
    end else begin
      s = acc + (MOD - 1 - card_value());
      if (s >= MOD) begin
`ifdef DEZ_END_AROUND_CARRY_EN
        s = s - MOD + 1;
`else
        s -= MOD;
        acc_ovf = 1'b1;
`endif
      end
    end
    acc = s;
    e.value = acc;
    e.ovf = acc_ovf;
    e.clr_after = clr_after;
    sb.push_back(e);
    if (clr_after) begin acc = 0; acc_ovf = 1'b0; end
  endtask

  task automatic set_card(input int v, input bit blank);
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      hole_d[i] = blank ? -1 : t % 10;
      hole_x[i] = -1;
      t = t / 10;
    end
  endtask

  task automatic rand_card();
    int r;
    for (int i = 0; i < D; i++) begin
      r = int'($urandom_range(0, 10));
      hole_d[i] = (r == 10) ? -1 : r;
      hole_x[i] = -1;
      if (hole_d[i] > 0 && $urandom_range(0, 3) == 0)
        hole_x[i] = int'($urandom_range(0, hole_d[i] - 1));
    end
  endtask

  // Init strobe plus index points 9..0; returns one cycle after idx 0.
  task automatic issue_card(input bit a, input bit s, input bit clr_mid);
    @(negedge clk);
    time_strobe = 1'b1; time_idx = 4'd12; add_req = a; sub_req = s;
    @(negedge clk);
    time_strobe = 1'b0; add_req = 1'b0; sub_req = 1'b0;
    repeat (D + 2) @(negedge clk);
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk);
      time_strobe = 1'b1; time_idx = 4'(k); data = holes_at(k);
      @(negedge clk);
      time_strobe = 1'b0; data = '0;
      if (k > 0) begin
        if (clr_mid && k == 5) begin
          clr = 1'b1;
          @(negedge clk);
          clr = 1'b0;
          repeat (D + 1) @(negedge clk);
        end else begin
          repeat (D + 2) @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    while (!done && lat < D + 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("done_latency_%0d", lat), longint'(done && lat >= 1 && lat <= D + 2), 1);
  endtask

  task automatic do_card(input bit sub, input bit clr_mid);
    model_card(sub, clr_mid);
    issue_card(!sub, sub, clr_mid);
    wait_done();
    repeat (3) @(negedge clk);
  endtask

  task automatic clr_idle();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    acc = 0;
    acc_ovf = 1'b0;
  endtask

  // Monitor: compare every completed card against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (clr_chk) begin
      check("held_clr_digits", longint'(digits), 0);
      check("held_clr_overflow", longint'(overflow), 0);
      clr_chk = 1'b0;
    end
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("digits", longint'(digits), longint'(to_bcd(e.value)));
        check("overflow", longint'(overflow), longint'(e.ovf));
        check("is_zero", longint'(is_zero), longint'(e.value == 0));
        check("is_nines", longint'(is_nines), longint'(e.value == MOD - 1));
        clr_chk = e.clr_after;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits", longint'(digits), 0);
    check("rst_is_zero", longint'(is_zero), 1);
    check("rst_is_nines", longint'(is_nines), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_overflow", longint'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    set_card(347, 1'b0); do_card(1'b0, 1'b0);   // 0347
    set_card(658, 1'b0); do_card(1'b0, 1'b0);   // 1005, ripple over places 0..2
    set_card(347, 1'b0); do_card(1'b1, 1'b0);   // 0658 / 0657+overflow
    clr_idle();
    set_card(1, 1'b0);   do_card(1'b0, 1'b1);   // 0001, then held clear
    set_card(0, 1'b1);   do_card(1'b1, 1'b0);   // 9999 from blank subtract

    // Neither or both requests: card ignored, accumulator untouched.
    rand_card();
    issue_card(1'b1, 1'b1, 1'b0);
    check("both_req_busy", longint'(busy), 0);
    rand_card();
    issue_card(1'b0, 1'b0, 1'b0);
    check("no_req_busy", longint'(busy), 0);
    repeat (D + 4) @(negedge clk);
    check("ignored_digits", longint'(digits), longint'(to_bcd(acc)));

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0) clr_idle();
      rand_card();
      do_card(1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a carry ripple.
    clr_idle();
    set_card(0, 1'b1); do_card(1'b1, 1'b0);     // 9999
    set_card(1, 1'b0);
    issue_card(1'b1, 1'b0, 1'b0);
    check("carry_busy", longint'(busy), 1);
    reset = 1'b0;
    #1;
    check("midrst_digits", longint'(digits), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_is_zero", longint'(is_zero), 1);
    check("midrst_is_nines", longint'(is_nines), 0);
    check("midrst_overflow", longint'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    acc = 0;
    acc_ovf = 1'b0;
    repeat (2) @(negedge clk);
    set_card(347, 1'b0); do_card(1'b0, 1'b0);

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
